muldiv_ctrl: RTL and testbench
==============================

// Module: muldiv_ctrl
// PURPOSE
//  Sequencer for the shared multi-cycle multiplier and iterative divider used by the EX stage.
//  Accepts one MULT/MULTU/DIV/DIVU op, latches operands, drives mul/div, raises stallreq_for_ex until done.
//  Then writes the 64-bit product/quotient+remainder into HI/LO with a 1-cycle res_valid pulse.
//  Sits between EX decode and the mul/div units; HI/LO outputs feed EX forwarding and the MFHI/MFLO path.
// PARAMETERS
//  MUL_LAT   2   cycles from mul operands stable to mul_result valid (>=1)
//  DIV_WDOG  48  max DIV_WAIT cycles before forced abort (div_annul pulse, no HI/LO write)
// PORTS
//  clk              in   1   clock, rising edge
//  rst              in   1   asynchronous, active-high reset
//  flush            in   1   synchronous pipeline flush; kill current op
//  op_valid         in   1   EX holds a mul/div op (held stable while stalled)
//  op_type          in   2   00 MULT, 01 MULTU, 10 DIV, 11 DIVU
//  src_a / src_b    in   32  operands (rs / rt)
//  mul_signed       out  1   signed multiply select
//  mul_ina/mul_inb  out  32  latched multiplier operands
//  mul_result       in   64  multiplier product
//  div_start        out  1   divider start, level, held until div_ready
//  div_signed       out  1   signed divide select
//  div_opa/div_opb  out  32  latched dividend / divisor
//  div_annul        out  1   1-cycle abort pulse to divider
//  div_ready        in   1   divider result valid (1 cycle)
//  div_result       in   64  {remainder[63:32], quotient[31:0]}
//  stallreq_for_ex  out  1   stall request to the stall controller
//  res_valid        out  1   1-cycle pulse: HI/LO updated this edge
//  hi / lo          out  32  HI/LO registers
// BEHAVIOUR
//  Reset: state=IDLE; hi, lo, operand regs, cnt = 0; res_valid, div_start, div_annul, stallreq_for_ex = 0.
//  States: IDLE, MUL_WAIT, DIV_WAIT, DONE; encoded state register, single always block per register group.
//  IDLE: op_valid & !flush -> latch src_a/src_b and op_type[0] (1=unsigned).
//        MULT/MULTU -> MUL_WAIT, cnt=MUL_LAT-1; DIV/DIVU -> DIV_WAIT, cnt=0.
//  stallreq_for_ex = (state==IDLE & op_valid & !flush) | MUL_WAIT | DIV_WAIT; 0 in DONE.
//  MUL_WAIT: cnt decrements; at cnt==0 capture {hi,lo}=mul_result -> DONE. MULT total = MUL_LAT+1 stall cycles.
//  DIV_WAIT: div_start=1, div_signed=~op_type[0]; div_ready -> {hi,lo}={rem,quo} -> DONE.
//  DONE: res_valid=1 for exactly this cycle, stall released; next edge -> IDLE.
//        op_valid seen in that next IDLE cycle is the following instruction.
//  Operands from latched regs only; src_a/src_b changes after the latch are ignored.
//  flush in any state: -> IDLE next edge, no HI/LO write, res_valid=0.
//        div_annul=1 for one cycle if flushed in DIV_WAIT.
//  flush and div_ready (or mul cnt==0) in same cycle: flush wins, result discarded.
//  Watchdog: cnt counts DIV_WAIT cycles; cnt==DIV_WDOG-1 without div_ready -> div_annul pulse, IDLE.
//        No write, stall released. Stall length DIV_WDOG.
//  Reset mid-operation: async clear to reset values; divider aborted via its own rst.
//  Signed mul: 64-bit two's-complement product. Unsigned: zero-extended operands.
// CONFIGURATION
//  MULDIV_DIV0_FAST_EN defined: DIV/DIVU with src_b==0 goes IDLE->DONE directly.
//        Divider not started; hi=src_a, lo=32'hFFFF_FFFF; 1 stall cycle.
//  Undefined: divide-by-zero runs through the divider like any other divide.
// TESTING
//  MULT a=32'hFFFF_FFFE(-2), b=3 -> stall 3 cycles (MUL_LAT=2), hi=32'hFFFF_FFFF, lo=32'hFFFF_FFFA, res_valid x1.
//  MULTU a=32'hFFFF_FFFF, b=2 -> hi=1, lo=32'hFFFF_FFFE.
//  DIV a=-7, b=2 with model ready after 33 cycles -> div_start high 33 cycles, lo=32'hFFFF_FFFD, hi=32'hFFFF_FFFF.
//  DIV flush on 10th DIV_WAIT cycle -> div_annul 1 pulse, IDLE, hi/lo unchanged, no res_valid.
//  Divider model never readies -> abort after 48 cycles, stall drops, hi/lo unchanged.
//  DIVU b=0 -> with MULDIV_DIV0_FAST_EN: 1 stall cycle, hi=a, lo=FFFF_FFFF; without: div_start asserted.
//  rst asserted mid-MUL_WAIT -> all outputs 0 immediately (async), next op processed normally.

Source files
------------

// File: rtl/muldiv_ctrl.sv
// muldiv_ctrl: sequencer between EX decode and the shared multiplier/divider.
// It accepts one MULT/MULTU/DIV/DIVU op and latches its operands. It holds the
// EX stage stalled while the selected unit works, then writes the 64-bit
// result into HI/LO and raises a single-cycle res_valid.
// Optional build macro MULDIV_DIV0_FAST_EN: divide by zero skips the divider
// and completes in one stall cycle with hi=dividend, lo=all ones.
module muldiv_ctrl #(
    parameter int MUL_LAT  = 2,   // cycles from stable operands to valid product (>=1)
    parameter int DIV_WDOG = 48   // DIV_WAIT cycles before the divider is abandoned
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        flush,
    input  logic        op_valid,
    input  logic [1:0]  op_type,
    input  logic [31:0] src_a,
    input  logic [31:0] src_b,
    output logic        mul_signed,
    output logic [31:0] mul_ina,
    output logic [31:0] mul_inb,
    input  logic [63:0] mul_result,
    output logic        div_start,
    output logic        div_signed,
    output logic [31:0] div_opa,
    output logic [31:0] div_opb,
    output logic        div_annul,
    input  logic        div_ready,
    input  logic [63:0] div_result,
    output logic        stallreq_for_ex,
    output logic        res_valid,
    output logic [31:0] hi,
    output logic [31:0] lo
);

    localparam int CNT_MAX = (DIV_WDOG > MUL_LAT) ? DIV_WDOG : MUL_LAT;
    localparam int CNT_W   = $clog2(CNT_MAX + 1);
    localparam logic [CNT_W-1:0] MUL_CNT_INIT = CNT_W'(MUL_LAT - 1);
    localparam logic [CNT_W-1:0] WDOG_LAST    = CNT_W'(DIV_WDOG - 1);

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        MUL_WAIT = 2'd1,
        DIV_WAIT = 2'd2,
        DONE     = 2'd3
    } state_t;

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             annul_q, annul_d;
    logic [31:0]      opa_q, opa_d;
    logic [31:0]      opb_q, opb_d;
    logic             signed_q, signed_d;
    logic [31:0]      hi_q, hi_d;
    logic [31:0]      lo_q, lo_d;

    logic accept;
    logic div0_fast;
    logic wdog_expire;

    // A new op is taken only from IDLE and only when the pipeline is not flushing it.
    assign accept = (state_q == IDLE) && op_valid && !flush;

`ifdef MULDIV_DIV0_FAST_EN
    assign div0_fast = op_type[1] && (src_b == 32'd0);
`else
    assign div0_fast = 1'b0;
`endif

    // Last permitted DIV_WAIT cycle with no answer from the divider.
    assign wdog_expire = (state_q == DIV_WAIT) && !div_ready && (cnt_q == WDOG_LAST);

    // Next-state, counter, operand latch and HI/LO update.
    always_comb begin
        // NOTE: every signal written here gets a default first, so no path can
        // leave one unassigned and infer a latch.
        state_d  = state_q;
        cnt_d    = cnt_q;
        annul_d  = 1'b0;
        opa_d    = opa_q;
        opb_d    = opb_q;
        signed_d = signed_q;
        hi_d     = hi_q;
        lo_d     = lo_q;

        case (state_q)
            IDLE: begin
                if (accept) begin
                    opa_d    = src_a;
                    opb_d    = src_b;
                    signed_d = ~op_type[0];
                    if (div0_fast) begin
                        hi_d    = src_a;
                        lo_d    = 32'hFFFF_FFFF;
                        state_d = DONE;
                    end else if (op_type[1]) begin
                        cnt_d   = '0;
                        state_d = DIV_WAIT;
                    end else begin
                        cnt_d   = MUL_CNT_INIT;
                        state_d = MUL_WAIT;
                    end
                end
            end
            MUL_WAIT: begin
                if (cnt_q == '0) begin
                    hi_d    = mul_result[63:32];
                    lo_d    = mul_result[31:0];
                    state_d = DONE;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            DIV_WAIT: begin
                if (div_ready) begin
                    hi_d    = div_result[63:32];
                    lo_d    = div_result[31:0];
                    state_d = DONE;
                end else if (wdog_expire) begin
                    annul_d = 1'b1;
                    state_d = IDLE;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        // A flush kills whatever is in flight, even a result arriving this cycle.
        if (flush) begin
            state_d = IDLE;
            hi_d    = hi_q;
            lo_d    = lo_q;
            annul_d = (state_q == DIV_WAIT);
        end
    end

    // Control registers: state, shared cycle counter, annul pulse.
    always_ff @(posedge clk or posedge rst) begin
        // NOTE: sequential state uses non-blocking assignment so every flop
        // samples the pre-edge value of every other flop.
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            annul_q <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            annul_q <= annul_d;
        end
    end

    // Latched operands and signedness, fed to both units.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            opa_q    <= '0;
            opb_q    <= '0;
            signed_q <= 1'b0;
        end else begin
            opa_q    <= opa_d;
            opb_q    <= opb_d;
            signed_q <= signed_d;
        end
    end

    // HI/LO architectural registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            hi_q <= '0;
            lo_q <= '0;
        end else begin
            hi_q <= hi_d;
            lo_q <= lo_d;
        end
    end

    assign mul_signed = signed_q;
    assign mul_ina    = opa_q;
    assign mul_inb    = opb_q;
    assign div_signed = signed_q;
    assign div_opa    = opa_q;
    assign div_opb    = opb_q;
    assign div_start  = (state_q == DIV_WAIT);
    assign div_annul  = annul_q;
    assign res_valid  = (state_q == DONE) && !flush;
    assign hi         = hi_q;
    assign lo         = lo_q;

    // The stall drops in the watchdog-expiry cycle so the abandoned divide
    // leaves EX on that edge. It is also held low during reset, because
    // accept looks at op_valid directly.
    assign stallreq_for_ex = !rst && (accept
                                      || (state_q == MUL_WAIT)
                                      || ((state_q == DIV_WAIT) && !wdog_expire));

endmodule

// File: tb/tb_muldiv_ctrl.sv
// Testbench for muldiv_ctrl. The driver issues ops and pushes expected HI/LO
// results into a scoreboard queue. A monitor pops and compares them on each
// res_valid. Stall, div_start and div_annul cycle counts are checked per op.
`timescale 1ns/1ps
module tb_muldiv_ctrl;

    localparam int MUL_LAT  = 2;
    localparam int DIV_WDOG = 48;

`ifdef MULDIV_DIV0_FAST_EN
    localparam bit FAST_DIV0 = 1'b1;
`else
    localparam bit FAST_DIV0 = 1'b0;
`endif

    localparam logic [1:0] OP_MULT  = 2'b00;
    localparam logic [1:0] OP_MULTU = 2'b01;
    localparam logic [1:0] OP_DIV   = 2'b10;
    localparam logic [1:0] OP_DIVU  = 2'b11;

    logic        clk = 1'b0;
    logic        rst;
    logic        flush;
    logic        op_valid;
    logic [1:0]  op_type;
    logic [31:0] src_a, src_b;
    logic        mul_signed;
    logic [31:0] mul_ina, mul_inb;
    logic [63:0] mul_result;
    logic        div_start, div_signed, div_annul, div_ready;
    logic [31:0] div_opa, div_opb;
    logic [63:0] div_result;
    logic        stallreq_for_ex, res_valid;
    logic [31:0] hi, lo;

    always #5 clk = ~clk;

    muldiv_ctrl #(.MUL_LAT(MUL_LAT), .DIV_WDOG(DIV_WDOG)) dut (
        .clk(clk), .rst(rst), .flush(flush), .op_valid(op_valid), .op_type(op_type),
        .src_a(src_a), .src_b(src_b), .mul_signed(mul_signed), .mul_ina(mul_ina),
        .mul_inb(mul_inb), .mul_result(mul_result), .div_start(div_start),
        .div_signed(div_signed), .div_opa(div_opa), .div_opb(div_opb),
        .div_annul(div_annul), .div_ready(div_ready), .div_result(div_result),
        .stallreq_for_ex(stallreq_for_ex), .res_valid(res_valid), .hi(hi), .lo(lo)
    );

    int checks = 0;
    int errors = 0;
    int op_id  = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Multiplier model: one register stage, so the product is valid MUL_LAT=2
    // cycles after the operands settle.
    logic [63:0] mul_pipe = '0;
    always @(posedge clk) begin
        if (mul_signed) mul_pipe <= 64'(longint'($signed(mul_ina)) * longint'($signed(mul_inb)));
        else            mul_pipe <= {32'd0, mul_ina} * {32'd0, mul_inb};
    end
    assign mul_result = mul_pipe;

    // Divider model: ready in the div_lat-th cycle of div_start (0 = never).
    int div_lat = 0;
    int dcnt = 0;
    always @(posedge clk) dcnt <= div_start ? dcnt + 1 : 0;
    assign div_ready = div_start && (div_lat != 0) && (dcnt == div_lat - 1);

    function automatic logic [63:0] divider_unit(input logic [31:0] a, input logic [31:0] b,
                                                 input logic sgn);
        logic [31:0] ma, mb, q, r;
        if (b == 32'd0) return {a, 32'hFFFF_FFFF};
        ma = (sgn && a[31]) ? -a : a;
        mb = (sgn && b[31]) ? -b : b;
        q  = ma / mb;
        r  = ma % mb;
        if (sgn && (a[31] ^ b[31])) q = -q;
        if (sgn && a[31])           r = -r;
        return {r, q};
    endfunction
    assign div_result = divider_unit(div_opa, div_opb, div_signed);

    // Reference: {hi,lo} an op must produce, from the original operands.
    function automatic logic [63:0] ref_result(input logic [1:0] t, input logic [31:0] a,
                                               input logic [31:0] b);
        longint sa, sb, q, r;
        logic [63:0] ua, ub;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        ua = {32'd0, a};
        ub = {32'd0, b};
        case (t)
            OP_MULT:  return 64'(sa * sb);
            OP_MULTU: return ua * ub;
            OP_DIV: begin
                if (b == 32'd0) return {a, 32'hFFFF_FFFF};
                q = sa / sb;
                r = sa % sb;
                return {32'(r), 32'(q)};
            end
            default: begin
                if (b == 32'd0) return {a, 32'hFFFF_FFFF};
                return {32'(ua % ub), 32'(ua / ub)};
            end
        endcase
    endfunction

    logic [63:0] exp_q[$];
    logic [31:0] model_hi = '0;
    logic [31:0] model_lo = '0;

    // Free-running event counters sampled mid-cycle.
    int n_stall = 0, n_start = 0, n_annul = 0, n_rv = 0;
    always @(negedge clk) begin
        if (stallreq_for_ex) n_stall <= n_stall + 1;
        if (div_start)       n_start <= n_start + 1;
        if (div_annul)       n_annul <= n_annul + 1;
        if (res_valid)       n_rv    <= n_rv + 1;
    end

    // Scoreboard monitor.
    always @(negedge clk) begin
        logic [63:0] e;
        if (!rst && res_valid) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_res_valid: got hi=%h lo=%h expected no result", hi, lo);
            end else begin
                e = exp_q.pop_front();
                check("res_hi", {32'd0, hi}, {32'd0, e[63:32]});
                check("res_lo", {32'd0, lo}, {32'd0, e[31:0]});
            end
        end
    end

    // Issue one op. Call at posedge+1; returns at posedge+1.
    task automatic run_op(input logic [1:0] t, input logic [31:0] a, input logic [31:0] b,
                          input int lat, input int flush_at, input bit gap);
        int ready_c, exp_stall, exp_start, exp_annul;
        int s0, st0, an0, rv0;
        bit is_div, fast, killed, complete, left;
        logic [63:0] res;
        op_id++;
        is_div = t[1];
        fast   = is_div && FAST_DIV0 && (b == 32'd0);
        if (!is_div)                            ready_c = MUL_LAT;
        else if (fast)                          ready_c = 0;
        else if (lat >= 1 && lat <= DIV_WDOG)   ready_c = lat;
        else                                    ready_c = -1;
        killed   = (flush_at >= 0) && (ready_c < 0 || flush_at <= ready_c);
        complete = !killed && (ready_c >= 0);
        if (killed)            exp_stall = flush_at + 1;
        else if (ready_c >= 0) exp_stall = ready_c + 1;
        else                   exp_stall = DIV_WDOG;
        if (!is_div || fast)   exp_start = 0;
        else if (killed)       exp_start = flush_at;
        else if (ready_c >= 0) exp_start = ready_c;
        else                   exp_start = DIV_WDOG;
        exp_annul = (is_div && !fast && (killed || ready_c < 0)) ? 1 : 0;
        if (complete) begin
            res = ref_result(t, a, b);
            exp_q.push_back(res);
        end

        s0 = n_stall; st0 = n_start; an0 = n_annul; rv0 = n_rv;
        op_valid = 1'b1; op_type = t; src_a = a; src_b = b; div_lat = lat;
        left = 1'b0;
        for (int c = 0; c < 200 && !left; c++) begin
            if (c > 0) begin
                @(posedge clk); #1;
                src_a = $urandom;
                src_b = $urandom;
            end
            flush = (c == flush_at);
            @(negedge clk); #1;
            if (flush || !stallreq_for_ex) left = 1'b1;
        end
        if (!left) begin
            checks++;
            errors++;
            $display("FAIL op%0d_timeout: stall still high after 200 cycles, required release", op_id);
        end
        check($sformatf("op%0d_stall_cycles", op_id), 64'(n_stall - s0), 64'(exp_stall));
        check($sformatf("op%0d_div_start_cycles", op_id), 64'(n_start - st0), 64'(exp_start));
        check($sformatf("op%0d_res_valid_count", op_id), 64'(n_rv - rv0), 64'(complete));
        @(posedge clk); #1;
        op_valid = 1'b0; flush = 1'b0;
        if (complete) begin
            model_hi = res[63:32];
            model_lo = res[31:0];
        end
        if (gap || !complete) begin
            @(negedge clk); #1;
            check($sformatf("op%0d_div_annul_count", op_id), 64'(n_annul - an0), 64'(exp_annul));
            check($sformatf("op%0d_hilo", op_id), {hi, lo}, {model_hi, model_lo});
            @(posedge clk); #1;
        end
    endtask

    task automatic check_zero(input string tag);
        check({tag, "_hilo"}, {hi, lo}, 64'd0);
        check({tag, "_ctl"}, 64'({stallreq_for_ex, res_valid, div_start, div_annul,
                                  mul_signed, div_signed}), 64'd0);
        check({tag, "_mul_ops"}, {mul_ina, mul_inb}, 64'd0);
        check({tag, "_div_ops"}, {div_opa, div_opb}, 64'd0);
    endtask

    initial begin
        logic [1:0]  t;
        logic [31:0] a, b;
        int lat, fa, rc;
        bit g;

        rst = 1'b1; flush = 1'b0; op_valid = 1'b0; op_type = 2'b00; src_a = '0; src_b = '0;
        #3;
        check_zero("reset");
        @(posedge clk); @(posedge clk); #1;
        rst = 1'b0;
        @(posedge clk); #1;

        run_op(OP_MULT,  32'hFFFF_FFFE, 32'd3, 0, -1, 1);        // -2*3
        run_op(OP_MULTU, 32'hFFFF_FFFF, 32'd2, 0, -1, 1);
        run_op(OP_DIV,   32'hFFFF_FFF9, 32'd2, 33, -1, 1);       // -7/2
        run_op(OP_DIV,   32'h0000_1234, 32'd7, 33, 10, 1);       // flush in 10th DIV_WAIT cycle
        run_op(OP_DIV,   32'h0000_0064, 32'd9, 0, -1, 1);        // watchdog abort
        run_op(OP_DIVU,  32'hDEAD_BEEF, 32'd0, 4, -1, 1);        // divide by zero
        run_op(OP_DIV,   32'h0000_0050, 32'd3, 5, 5, 1);         // flush with div_ready
        run_op(OP_MULT,  32'h0000_1111, 32'd5, 0, 2, 1);         // flush with product capture
        run_op(OP_DIVU,  32'hFFFF_FFF0, 32'd3, DIV_WDOG, -1, 1); // ready on last watchdog cycle
        run_op(OP_MULT,  32'h8000_0000, 32'h8000_0000, 0, -1, 0);// back-to-back pair
        run_op(OP_DIV,   32'h8000_0000, 32'hFFFF_FFFF, 3, -1, 1);

        // Asynchronous reset in the middle of MUL_WAIT.
        op_valid = 1'b1; op_type = OP_MULTU; src_a = 32'h0000_0123; src_b = 32'h0000_0456; div_lat = 0;
        @(posedge clk); #1;
        #2 rst = 1'b1;
        #1;
        check_zero("mid_op_reset");
        op_valid = 1'b0;
        exp_q.delete();
        model_hi = '0;
        model_lo = '0;
        @(posedge clk); #1;
        rst = 1'b0;
        @(posedge clk); #1;
        run_op(OP_MULT, 32'h0000_0007, 32'hFFFF_FFFD, 0, -1, 1);

        for (int i = 0; i < 40; i++) begin
            t = 2'($urandom_range(0, 3));
            a = $urandom;
            b = $urandom;
            if ($urandom_range(0, 3) == 0) a = 32'h8000_0000;
            if (t[1] && $urandom_range(0, 7) == 0) b = 32'd0;
            lat = $urandom_range(0, 52);
            if (!t[1])                              rc = MUL_LAT;
            else if (FAST_DIV0 && b == 32'd0)       rc = 0;
            else if (lat >= 1 && lat <= DIV_WDOG)   rc = lat;
            else                                    rc = DIV_WDOG - 1;
            fa = -1;
            if (rc > 0 && $urandom_range(0, 4) == 0) fa = $urandom_range(1, rc);
            g = 1'($urandom_range(0, 1));
            run_op(t, a, b, lat, fa, g);
        end

        repeat (3) @(posedge clk);
        #1;
        check("scoreboard_drained", 64'(exp_q.size()), 64'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL global_timeout: simulation still running at 2ms, required finish");
        $fatal(1, "global timeout");
    end

endmodule
